button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//  Front-end stage for the calculator datapath. Takes the raw, bouncing, asynchronous push-buttons
//  (digit-increment, operator and clear keys) and brings them into the system clock domain.
//  Produces three outputs: debounced levels, single-cycle press pulses, and one encoded key event
//  with a valid/ready handshake. Downstream logic runs entirely on clk and never uses a button as a clock.
// PARAMETERS
//  NUM_BTN          9          number of button inputs (index 0..NUM_BTN-1)
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable clk samples needed to accept a level change (10 ms @ 100 MHz)
//  REPEAT_DELAY     50_000_000 hold time before the first auto-repeat pulse (AUTO_REPEAT_EN only)
//  REPEAT_PERIOD    20_000_000 interval between later auto-repeat pulses (AUTO_REPEAT_EN only)
// PORTS
//  clk        in   1        system clock
//  rst        in   1        reset, asynchronous, active-low
//  btn_raw    in   NUM_BTN  raw button pins, asynchronous, active-high
//  btn_level  out  NUM_BTN  debounced button level
//  btn_pulse  out  NUM_BTN  one-clk pulse per accepted press (and per repeat when enabled)
//  key_valid  out  1        encoded key event pending
//  key_code   out  4        index of the pending button (0..NUM_BTN-1)
//  key_ready  in   1        consumer accepts the event on a clk edge where key_valid && key_ready
//  key_ovf    out  1        sticky: a press was dropped; cleared only by reset
// BEHAVIOUR
//  - Reset (rst=0, async): sync FFs, levels, pulses, key_valid, key_code and key_ovf all go to 0.
//    Every per-button FSM goes to IDLE_LO with its counter at 0. All state is held while rst=0.
//  - Synchronizer: 2-FF chain per button. Its output is s.
//  - Per-button FSM with states IDLE_LO, CHK_HI, IDLE_HI, CHK_LO:
//    IDLE_LO: s=1 -> CHK_HI, counter := 1.
//    CHK_HI: s=0 -> IDLE_LO, counter := 0 (bounce rejected).
//      Counter reaches DEBOUNCE_CYCLES -> IDLE_HI, level := 1, pulse := 1 for one cycle.
//    IDLE_HI and CHK_LO mirror the above. Release never produces a pulse.
//  - Latency: raw edge to btn_pulse = 2 sync cycles + DEBOUNCE_CYCLES, with a clean input.
//  - The counter saturates and never wraps. Counter width is $clog2(DEBOUNCE_CYCLES+1).
//  - Key event: registered. Any btn_pulse bit in cycle N gives key_valid=1 at edge N+1,
//    with key_code = lowest index among the pulsing bits.
//    key_valid and key_code hold stable until a transfer (valid && ready).
//    A transfer and a new pulse in the same cycle: the new event loads and key_valid stays 1 (back-to-back).
//    A pulse while an event is pending and not transferring: the new press is dropped, key_ovf := 1.
//    Simultaneous pulses: the extra bits appear only on btn_pulse, and key_ovf := 1.
//  - key_code is 0 whenever key_valid=0.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//    While a button sits in IDLE_HI, a per-button repeat counter emits a pulse after REPEAT_DELAY cycles,
//    then one every REPEAT_PERIOD cycles. Repeat pulses feed the key-event logic exactly like presses.
//    Leaving IDLE_HI clears the repeat counter.
//  AUTO_REPEAT_EN undefined: no repeat counters and exactly one pulse per press. REPEAT_* are ignored.
// STRUCTURE
//  calc_pkg: NUM_BTN default, button index constants
//    (BTN_N1_TENS=0, BTN_N1_ONES, BTN_N2_TENS, BTN_N2_ONES, BTN_ADD, BTN_SUB, BTN_MUL, BTN_DIV, BTN_CLR=8),
//    and the btn_state_t enum {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO}.
//  Sub-module btn_debounce: sync + FSM + counter (+ repeat), instantiated NUM_BTN times via generate.
//  The top level holds the priority encoder, event register and overflow flag.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1. Clean press of btn 5, held 20 cycles
//     -> btn_pulse[5] high exactly once, 6 cycles after the raw edge; btn_level[5]=1;
//        key_valid=1 with key_code=5 on the next cycle.
//  2. Btn 2 toggles 1,0,1,0,1 at 1-cycle spacing, then stays high
//     -> no pulse during the bounce; a single pulse 4 stable cycles after the final rise.
//  3. key_ready=0 with a pending code 3, then btn 7 pressed
//     -> key_code stays 3 and key_ovf=1. Then key_ready=1 -> transfer and key_valid=0.
//  4. Btns 1 and 6 accepted in the same cycle, key_ready=1
//     -> key_code=1, btn_pulse=9'b001000010, key_ovf=1.
//  5. rst asserted mid-CHK_HI on btn 0 (counter=2)
//     -> all outputs go to 0 at once; after release a fresh 4-cycle qualification is needed.
//  6. AUTO_REPEAT_EN, btn 4 held 30 cycles past acceptance
//     -> pulses at +0, +10, +13, +16, ... ; none without the macro.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: button count, button indices
// and the per-button debounce state encoding.
package calc_pkg;

   localparam int NUM_BTN_DEF = 9;

   localparam int BTN_N1_TENS = 0;
   localparam int BTN_N1_ONES = 1;
   localparam int BTN_N2_TENS = 2;
   localparam int BTN_N2_ONES = 3;
   localparam int BTN_ADD     = 4;
   localparam int BTN_SUB     = 5;
   localparam int BTN_MUL     = 6;
   localparam int BTN_DIV     = 7;
   localparam int BTN_CLR     = 8;

   typedef enum logic [1:0] {
      IDLE_LO,
      CHK_HI,
      IDLE_HI,
      CHK_LO
   } btn_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, debounce FSM with saturating stability counter,
// and an optional hold-to-repeat generator (enabled by defining AUTO_REPEAT_EN).
module btn_debounce
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 20_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             r_sync1;
   logic             r_sync2;
   logic             w_s;
   btn_state_t       r_state;
   btn_state_t       w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_level;
   logic             w_level_next;
   logic             r_pulse;
   logic             w_pulse_next;
   logic             w_rpt_fire;

   assign w_s       = r_sync2;
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= IDLE_LO;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_level <= w_level_next;
         r_pulse <= w_pulse_next;
      end
   end

   // The counter holds the number of consecutive samples agreeing with the new level.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_level_next = r_level;
      w_pulse_next = 1'b0;
      case (r_state)
         IDLE_LO: begin
            if (w_s) begin
               w_state_next = CHK_HI;
               w_cnt_next   = CNT_W'(1);
            end
         end
         CHK_HI: begin
            if (!w_s) begin
               w_state_next = IDLE_LO;
               w_cnt_next   = '0;
            end else if (w_cnt_inc == CNT_MAX) begin
               w_state_next = IDLE_HI;
               w_cnt_next   = '0;
               w_level_next = 1'b1;
               w_pulse_next = 1'b1;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
         end
         IDLE_HI: begin
            if (!w_s) begin
               w_state_next = CHK_LO;
               w_cnt_next   = CNT_W'(1);
            end else begin
               w_pulse_next = w_rpt_fire;
            end
         end
         CHK_LO: begin
            if (w_s) begin
               w_state_next = IDLE_HI;
               w_cnt_next   = '0;
            end else if (w_cnt_inc == CNT_MAX) begin
               w_state_next = IDLE_LO;
               w_cnt_next   = '0;
               w_level_next = 1'b0;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
         end
         default: begin
            w_state_next = IDLE_LO;
            w_cnt_next   = '0;
         end
      endcase
   end

`ifdef AUTO_REPEAT_EN
   localparam int RPT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   logic [RPT_W-1:0] r_rpt_cnt;
   logic [RPT_W-1:0] w_rpt_cnt_next;
   logic [RPT_W-1:0] w_rpt_target;
   logic             r_rpt_first;
   logic             w_rpt_first_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rpt_cnt   <= '0;
         r_rpt_first <= 1'b1;
      end else begin
         r_rpt_cnt   <= w_rpt_cnt_next;
         r_rpt_first <= w_rpt_first_next;
      end
   end

   // Anything other than a steady hold restarts the sequence with the long first delay.
   always_comb begin
      w_rpt_target     = r_rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);
      w_rpt_fire       = (r_state == IDLE_HI) && w_s && (r_rpt_cnt + RPT_W'(1) == w_rpt_target);
      w_rpt_cnt_next   = '0;
      w_rpt_first_next = 1'b1;
      if ((r_state == IDLE_HI) && w_s) begin
         if (w_rpt_fire) begin
            w_rpt_first_next = 1'b0;
         end else begin
            w_rpt_cnt_next   = r_rpt_cnt + RPT_W'(1);
            w_rpt_first_next = r_rpt_first;
         end
      end
   end
`else
   logic w_rpt_unused;

   assign w_rpt_fire   = 1'b0;
   assign w_rpt_unused = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

   assign o_level = r_level;
   assign o_pulse = r_pulse;

endmodule

// File: rtl/button_conditioner.sv
// Calculator button front end: per-button debouncers plus a single registered key-event
// channel (lowest index wins, sticky overflow). Define AUTO_REPEAT_EN for hold-to-repeat.
module button_conditioner
   import calc_pkg::*;
#(
   parameter int NUM_BTN         = NUM_BTN_DEF,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 20_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse,
   output logic               key_valid,
   output logic [3:0]         key_code,
   input  logic               key_ready,
   output logic               key_ovf
);

   logic       r_key_valid;
   logic [3:0] r_key_code;
   logic       r_key_ovf;
   logic [3:0] w_code;
   logic       w_any;
   logic       w_multi;
   logic       w_xfer;
   logic       w_load;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_debounce (
         .clk     (clk),
         .rst     (rst),
         .i_raw   (btn_raw[gi]),
         .o_level (btn_level[gi]),
         .o_pulse (btn_pulse[gi])
      );
   end

   always_comb begin
      w_code = 4'd0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (btn_pulse[i]) begin
            w_code = 4'(i);
         end
      end
   end

   // x & (x-1) is non-zero exactly when more than one bit is set.
   assign w_any   = |btn_pulse;
   assign w_multi = |(btn_pulse & (btn_pulse - NUM_BTN'(1)));
   assign w_xfer  = r_key_valid && key_ready;
   assign w_load  = w_any && (!r_key_valid || w_xfer);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_key_valid <= 1'b0;
         r_key_code  <= 4'd0;
         r_key_ovf   <= 1'b0;
      end else begin
         if (w_load) begin
            r_key_valid <= 1'b1;
            r_key_code  <= w_code;
         end else if (w_xfer) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
         end
         if (w_multi || (w_any && !w_load)) begin
            r_key_ovf <= 1'b1;
         end
      end
   end

   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign key_ovf   = r_key_ovf;

endmodule
